// File: rtl/access_initiator.sv
// access_initiator
// Turns register commands into a byte stream for an SPI link master.
// Each transaction is an address byte followed by data byte(s), with at
// most one byte in flight on the link at a time.
//   op 00 write : {1'b1, addr}, then cmd_wdata
//   op 01 read  : {1'b0, addr}, then dummy 8'h00; the reply lands on rsp_data
//   op 10 burst : 8'hFF, then NREGWR bytes fetched one at a time from bd_*
//   op 11, or an out-of-range address: rejected with done+err, no link traffic
//
// Ports
//   clk, rst (asynchronous, active low)
//   cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_wdata : command handshake
//   bd_req/bd_valid/bd_data                       : burst byte source
//   tx_valid/tx_ready/tx_data                     : byte toward the link
//   rx_valid/rx_data                              : exchange completion from the link
//   rsp_valid/rsp_data                            : read result
//   done/err                                      : end-of-command pulses
module access_initiator #(
  parameter int NREGWR = 41,
  parameter int NREGR  = 6,
  localparam int AW = $clog2(NREGWR + NREGR)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [7:0]    cmd_wdata,
  output logic          bd_req,
  input  logic          bd_valid,
  input  logic [7:0]    bd_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [7:0]    tx_data,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rsp_valid,
  output logic [7:0]    rsp_data,
  output logic          done,
  output logic          err
);

  localparam int CW  = $clog2(NREGWR + 1);
  localparam int AWP = AW + 1;

  // Limits are one bit wider than the address so a register count that is an
  // exact power of two still fits.
  localparam logic [AW:0]   WR_LIMIT  = AWP'(NREGWR);
  localparam logic [AW:0]   RD_LIMIT  = AWP'(NREGWR + NREGR);
  localparam logic [CW-1:0] BURST_LEN = CW'(NREGWR);

  typedef enum logic [2:0] {
    IDLE,
    SEND_A,
    WAIT_A,
    SEND_D,
    WAIT_D,
    FIN
  } state_t;

  typedef enum logic [1:0] {
    OP_WR    = 2'b00,
    OP_RD    = 2'b01,
    OP_BURST = 2'b10,
    OP_RSVD  = 2'b11
  } op_t;

  state_t        state;
  op_t           op_q;
  logic [7:0]    wdata_q;
  logic [CW-1:0] cnt;

  logic          cmd_bad;
  logic [7:0]    addr_byte;
  logic [AW:0]   addr_ext;

  assign addr_ext = {1'b0, cmd_addr};

  // Command decode: legality check and the address byte to put on the link.
  always_comb begin
    cmd_bad   = 1'b0;
    addr_byte = 8'h00;
    case (op_t'(cmd_op))
      OP_WR: begin
        cmd_bad   = (addr_ext >= WR_LIMIT);
        addr_byte = {1'b1, 7'(cmd_addr)};
      end
      OP_RD: begin
        cmd_bad   = (addr_ext >= RD_LIMIT);
        addr_byte = {1'b0, 7'(cmd_addr)};
      end
      OP_BURST: begin
        addr_byte = 8'hFF;
      end
      default: begin
        cmd_bad = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      op_q      <= OP_WR;
      wdata_q   <= 8'h00;
      cnt       <= '0;
      cmd_ready <= 1'b0;
      bd_req    <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      // Single-cycle pulses default low.
      bd_req    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rsp_valid <= 1'b0;

      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            op_q      <= op_t'(cmd_op);
            wdata_q   <= cmd_wdata;
            cnt       <= '0;
            // Rejected commands still pass through FIN so done/err appear
            // with cmd_ready low, exactly like a completed command.
            if (cmd_bad) begin
              done  <= 1'b1;
              err   <= 1'b1;
              state <= FIN;
            end else begin
              tx_data  <= addr_byte;
              tx_valid <= 1'b1;
              state    <= SEND_A;
            end
          end
        end

        SEND_A: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= WAIT_A;
          end
        end

        WAIT_A: begin
          if (rx_valid) begin
            state <= SEND_D;
            if (op_q == OP_BURST) begin
              bd_req <= 1'b1;
            end else begin
              tx_data  <= (op_q == OP_WR) ? wdata_q : 8'h00;
              tx_valid <= 1'b1;
            end
          end
        end

        SEND_D: begin
          // tx_valid low here only in a burst, while waiting for the source.
          if (tx_valid) begin
            if (tx_ready) begin
              tx_valid <= 1'b0;
              state    <= WAIT_D;
              if (op_q == OP_BURST) begin
                cnt <= cnt + 1'b1;
              end
            end
          end else if (bd_valid) begin
            tx_data  <= bd_data;
            tx_valid <= 1'b1;
          end
        end

        WAIT_D: begin
          if (rx_valid) begin
            if (op_q == OP_BURST && cnt != BURST_LEN) begin
              bd_req <= 1'b1;
              state  <= SEND_D;
            end else begin
              done  <= 1'b1;
              state <= FIN;
              if (op_q == OP_RD) begin
                rsp_data  <= rx_data;
                rsp_valid <= 1'b1;
              end
            end
          end
        end

        FIN: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_access_initiator.sv
// tb_access_initiator
// Directed bench for access_initiator. A link responder records every
// accepted byte and answers with rx_valid a few cycles later; a burst source
// answers each bd_req with the next byte of a 0,1,2... sequence. Monitors
// count the single-cycle pulses so the main sequence can compare deltas.
module tb_access_initiator;

  localparam int NREGWR = 41;
  localparam int NREGR  = 6;
  localparam int AW     = $clog2(NREGWR + NREGR);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_wdata;
  logic          bd_req;
  logic          bd_valid;
  logic [7:0]    bd_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [7:0]    tx_data;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rsp_valid;
  logic [7:0]    rsp_data;
  logic          done;
  logic          err;

  access_initiator #(.NREGWR(NREGWR), .NREGR(NREGR)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .bd_req    (bd_req),
    .bd_valid  (bd_valid),
    .bd_data   (bd_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int errorCount = 0;

  // Link responder state
  logic [7:0] linkBytes [0:511];
  int         linkCount   = 0;
  int         cmdStartIdx = 0;
  int         rxDelay     = 0;
  logic [7:0] replyPending = 8'h00;
  logic [7:0] rxReply      = 8'h00;

  // Burst source state
  int bdReqCount = 0;
  int bdServed   = 0;
  int bdDelay    = 0;
  int burstBase  = 0;

  // Pulse monitors
  int doneCount   = 0;
  int errCount    = 0;
  int rspCount    = 0;
  int rspWithDone = 0;
  int txHighCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Link side: the address byte of each command is answered with junk so a
  // read that captured the wrong exchange shows up on rsp_data.
  initial begin
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    forever begin
      @(negedge clk);
      rx_valid = 1'b0;
      if (rxDelay > 0) begin
        rxDelay--;
        if (rxDelay == 0) begin
          rx_valid = 1'b1;
          rx_data  = replyPending;
        end
      end
      if (tx_valid && tx_ready) begin
        if (linkCount < 512) linkBytes[linkCount] = tx_data;
        replyPending = (linkCount == cmdStartIdx) ? 8'h5A : rxReply;
        linkCount++;
        rxDelay = 3;
      end
    end
  end

  initial begin
    bd_valid = 1'b0;
    bd_data  = 8'h00;
    forever begin
      @(negedge clk);
      bd_valid = 1'b0;
      if (bdDelay > 0) begin
        bdDelay--;
        if (bdDelay == 0) begin
          bd_valid = 1'b1;
          bd_data  = 8'(bdServed - burstBase);
          bdServed++;
        end
      end
      if (bd_req) begin
        bdReqCount++;
        bdDelay = 2;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done) doneCount++;
      if (err) errCount++;
      if (tx_valid) txHighCount++;
      if (rsp_valid) begin
        rspCount++;
        if (done) rspWithDone++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic stepCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) stepCycle();
  endtask

  // Waits for cmd_ready, then presents one command for exactly one cycle.
  task automatic applyStimulus(input logic [1:0] op, input logic [AW-1:0] addr, input logic [7:0] wdata);
    int waited = 0;
    while (cmd_ready !== 1'b1 && waited < 50) begin
      stepCycle();
      waited++;
    end
    checkOutput("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmdStartIdx = linkCount;
    cmd_op      = op;
    cmd_addr    = addr;
    cmd_wdata   = wdata;
    cmd_valid   = 1'b1;
    stepCycle();
    cmd_valid   = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int limit);
    int cycles = 0;
    while (done !== 1'b1 && cycles < limit) begin
      stepCycle();
      cycles++;
    end
    checkOutput($sformatf("%s_done_seen", tag), 32'(done), 32'd1);
  endtask

  task automatic runSingle(input string tag, input logic [1:0] op, input logic [AW-1:0] addr,
                           input logic [7:0] wdata, input logic [7:0] reply,
                           input logic [7:0] expAddr, input logic [7:0] expData);
    int ls, ds, es, rs, rw;
    rxReply = reply;
    ls = linkCount;
    ds = doneCount;
    es = errCount;
    rs = rspCount;
    rw = rspWithDone;
    applyStimulus(op, addr, wdata);
    waitDone(tag, 300);
    settle(8);
    checkOutput($sformatf("%s_nbytes", tag), 32'(linkCount - ls), 32'd2);
    checkOutput($sformatf("%s_addr_byte", tag), 32'(linkBytes[ls]), 32'(expAddr));
    checkOutput($sformatf("%s_data_byte", tag), 32'(linkBytes[ls + 1]), 32'(expData));
    checkOutput($sformatf("%s_done_cnt", tag), 32'(doneCount - ds), 32'd1);
    checkOutput($sformatf("%s_err_cnt", tag), 32'(errCount - es), 32'd0);
    if (op == 2'b01) begin
      checkOutput($sformatf("%s_rsp_cnt", tag), 32'(rspCount - rs), 32'd1);
      checkOutput($sformatf("%s_rsp_with_done", tag), 32'(rspWithDone - rw), 32'd1);
      checkOutput($sformatf("%s_rsp_data", tag), 32'(rsp_data), 32'(reply));
    end else begin
      checkOutput($sformatf("%s_rsp_cnt", tag), 32'(rspCount - rs), 32'd0);
    end
  endtask

  task automatic runReject(input string tag, input logic [1:0] op, input logic [AW-1:0] addr);
    int ls, ds, es, th;
    ls = linkCount;
    ds = doneCount;
    es = errCount;
    th = txHighCount;
    applyStimulus(op, addr, 8'hEE);
    // Acceptance edge has just passed: done and err must already be up.
    checkOutput($sformatf("%s_done_now", tag), 32'(done), 32'd1);
    checkOutput($sformatf("%s_err_now", tag), 32'(err), 32'd1);
    settle(6);
    checkOutput($sformatf("%s_done_cnt", tag), 32'(doneCount - ds), 32'd1);
    checkOutput($sformatf("%s_err_cnt", tag), 32'(errCount - es), 32'd1);
    checkOutput($sformatf("%s_nbytes", tag), 32'(linkCount - ls), 32'd0);
    checkOutput($sformatf("%s_tx_high", tag), 32'(txHighCount - th), 32'd0);
  endtask

  initial begin
    int ls, ds, es, bs, held, waited;

    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_addr  = '0;
    cmd_wdata = 8'h00;
    tx_ready  = 1'b1;

    // Reset asserted between clock edges; outputs must clear without a clock.
    #1 rst = 1'b0;
    #2;
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
    checkOutput("rst_bd_req", 32'(bd_req), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    settle(3);
    rst = 1'b1;
    settle(2);
    checkOutput("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    $display("[TB] single write / read");
    runSingle("wr5", 2'b00, 6'd5, 8'h3C, 8'h11, 8'h85, 8'h3C);
    runSingle("rd42", 2'b01, 6'd42, 8'h00, 8'hA7, 8'h2A, 8'h00);
    checkOutput("rsp_hold", 32'(rsp_data), 32'hA7);
    runSingle("wr40", 2'b00, 6'd40, 8'hC5, 8'h22, 8'hA8, 8'hC5);
    runSingle("rd46", 2'b01, 6'd46, 8'h00, 8'h64, 8'h2E, 8'h00);
    runSingle("rd0", 2'b01, 6'd0, 8'h00, 8'h9B, 8'h00, 8'h00);

    $display("[TB] rejected commands");
    runReject("rej_wr41", 2'b00, 6'd41);
    runReject("rej_rd47", 2'b01, 6'd47);
    runReject("rej_op3", 2'b11, 6'd2);

    $display("[TB] link back-pressure");
    tx_ready = 1'b0;
    ls = linkCount;
    ds = doneCount;
    applyStimulus(2'b00, 6'd3, 8'h5E);
    held = 0;
    repeat (10) begin
      stepCycle();
      if (tx_valid !== 1'b1 || tx_data !== 8'h83) held++;
    end
    checkOutput("stall_unstable_cycles", 32'(held), 32'd0);
    checkOutput("stall_no_bytes", 32'(linkCount - ls), 32'd0);
    @(posedge clk);
    #1 tx_ready = 1'b1;
    waitDone("stall", 300);
    settle(8);
    checkOutput("stall_nbytes", 32'(linkCount - ls), 32'd2);
    checkOutput("stall_addr_byte", 32'(linkBytes[ls]), 32'h83);
    checkOutput("stall_data_byte", 32'(linkBytes[ls + 1]), 32'h5E);
    checkOutput("stall_done_cnt", 32'(doneCount - ds), 32'd1);

    $display("[TB] full burst");
    burstBase = bdServed;
    ls = linkCount;
    ds = doneCount;
    es = errCount;
    bs = bdReqCount;
    applyStimulus(2'b10, 6'd13, 8'h00);
    waitDone("burst", 3000);
    settle(10);
    checkOutput("burst_nbytes", 32'(linkCount - ls), 32'(NREGWR + 1));
    checkOutput("burst_hdr", 32'(linkBytes[ls]), 32'hFF);
    for (int i = 0; i < NREGWR; i++) begin
      checkOutput($sformatf("burst_byte%0d", i), 32'(linkBytes[ls + 1 + i]), 32'(i));
    end
    checkOutput("burst_bd_req_cnt", 32'(bdReqCount - bs), 32'(NREGWR));
    checkOutput("burst_done_cnt", 32'(doneCount - ds), 32'd1);
    checkOutput("burst_err_cnt", 32'(errCount - es), 32'd0);

    $display("[TB] reset during burst");
    burstBase = bdServed;
    ds = doneCount;
    bs = bdReqCount;
    applyStimulus(2'b10, 6'd0, 8'h00);
    waited = 0;
    while ((bdReqCount - bs) < 20 && waited < 2000) begin
      stepCycle();
      waited++;
    end
    checkOutput("midburst_reached", 32'(bdReqCount - bs), 32'd20);
    stepCycle();
    rst = 1'b0;
    #1;
    checkOutput("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("midrst_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("midrst_tx_data", 32'(tx_data), 32'd0);
    checkOutput("midrst_bd_req", 32'(bd_req), 32'd0);
    checkOutput("midrst_rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    settle(3);
    rst = 1'b1;
    settle(12);
    checkOutput("midrst_no_done", 32'(doneCount - ds), 32'd0);
    checkOutput("midrst_cmd_ready_back", 32'(cmd_ready), 32'd1);
    runSingle("post_rst_wr7", 2'b00, 6'd7, 8'hC3, 8'h33, 8'h87, 8'hC3);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
